// File: rtl/psdu_extractor.sv
// PSDU extractor: strips the SERVICE field from a descrambled bit stream,
// assembles LSB-first PSDU bytes and flags frame completion.
module psdu_extractor #(
    parameter int LEN_WIDTH    = 12,
    parameter int SERVICE_BITS = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [LEN_WIDTH-1:0] Length,
    input  logic                 Input,
    input  logic                 InputValid,
    output logic [7:0]           Output,
    output logic                 OutputValid,
    output logic                 Done,
    output logic                 Busy,
    output logic                 ServiceError
);

    localparam int CW = (SERVICE_BITS > 8) ? $clog2(SERVICE_BITS) : 3;
    localparam logic [CW-1:0] SVC_LAST  = CW'(SERVICE_BITS - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(7);

    typedef enum logic [1:0] {
        IDLE,
        SERVICE,
        PSDU,
        DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_byte_cnt;
    logic [CW-1:0]        r_bit_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_out;
    logic                 r_ov;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_serr;
    logic                 w_svc_last;
    logic                 w_byte_full;
    logic                 w_last_byte;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start has priority everywhere so it can abort a frame in flight.
    always_comb begin
        w_state_next = r_state;
        w_svc_last   = 1'b0;
        w_byte_full  = 1'b0;
        w_last_byte  = 1'b0;
        if (Start) begin
            w_state_next = SERVICE;
        end else begin
            case (r_state)
                SERVICE: begin
                    if (InputValid && r_bit_cnt == SVC_LAST) begin
                        w_svc_last   = 1'b1;
                        w_state_next = (r_len == '0) ? DRAIN : PSDU;
                    end
                end
                PSDU: begin
                    if (InputValid && r_bit_cnt == BYTE_LAST) begin
                        w_byte_full = 1'b1;
                        // Compare against Length-1 so a full-scale Length never overflows.
                        if (r_byte_cnt == r_len - LEN_WIDTH'(1)) begin
                            w_last_byte  = 1'b1;
                            w_state_next = DRAIN;
                        end
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_out      <= '0;
            r_ov       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_ov   <= 1'b0;
            r_done <= 1'b0;
            if (Start) begin
                r_len      <= Length;
                r_byte_cnt <= '0;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_serr     <= 1'b0;
                r_busy     <= 1'b1;
            end else if (InputValid) begin
                case (r_state)
                    SERVICE: begin
                        r_serr <= r_serr | Input;
                        if (w_svc_last) begin
                            r_bit_cnt <= '0;
                            if (r_len == '0) begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
                    PSDU: begin
                        r_shift <= {Input, r_shift[7:1]};
                        if (w_byte_full) begin
                            r_out      <= {Input, r_shift[7:1]};
                            r_ov       <= 1'b1;
                            r_byte_cnt <= r_byte_cnt + LEN_WIDTH'(1);
                            r_bit_cnt  <= '0;
                            if (w_last_byte) begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Output       = r_out;
    assign OutputValid  = r_ov;
    assign Done         = r_done;
    assign Busy         = r_busy;
    assign ServiceError = r_serr;

endmodule

// File: tb/tb_psdu_extractor.sv
// Testbench for psdu_extractor: frame-level reference model compared every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_psdu_extractor;

    localparam int LW = 12;
    localparam int SB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          din = 1'b0;
    logic          din_v = 1'b0;
    logic [7:0]    dout;
    logic          dout_v;
    logic          done;
    logic          busy;
    logic          serr;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [7:0] log_q[$];

    psdu_extractor #(.LEN_WIDTH(LW), .SERVICE_BITS(SB)) dut (
        .Clock(clk),
        .Reset(rst),
        .Start(start),
        .Length(len),
        .Input(din),
        .InputValid(din_v),
        .Output(dout),
        .OutputValid(dout_v),
        .Done(done),
        .Busy(busy),
        .ServiceError(serr)
    );

    always #5 clk = ~clk;

    // Reference model: counts valid bits since Start and derives outputs by position.
    logic [7:0] m_out;
    logic [7:0] m_acc;
    logic       m_ov;
    logic       m_done;
    logic       m_busy;
    logic       m_serr;
    logic       m_active;
    int         m_n;
    int         m_len;

    function automatic logic [7:0] setbit(input logic [7:0] v, input int i, input logic b);
        logic [7:0] r;
        r = v;
        r[i] = b;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out <= '0; m_acc <= '0; m_ov <= 1'b0; m_done <= 1'b0;
            m_busy <= 1'b0; m_serr <= 1'b0; m_active <= 1'b0; m_n <= 0; m_len <= 0;
        end else begin
            m_ov   <= 1'b0;
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_len    <= int'(len);
                m_n      <= 0;
                m_serr   <= 1'b0;
                m_busy   <= 1'b1;
            end else if (m_active && din_v) begin
                m_n <= m_n + 1;
                if (m_n < SB) begin
                    if (din) m_serr <= 1'b1;
                    if (m_n == SB - 1 && m_len == 0) begin
                        m_done <= 1'b1; m_busy <= 1'b0; m_active <= 1'b0;
                    end
                end else if (m_n - SB < 8 * m_len) begin
                    m_acc <= setbit(m_acc, (m_n - SB) % 8, din);
                    if ((m_n - SB) % 8 == 7) begin
                        m_out <= setbit(m_acc, 7, din);
                        m_ov  <= 1'b1;
                        if ((m_n - SB) / 8 == m_len - 1) begin
                            m_done <= 1'b1; m_busy <= 1'b0; m_active <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if ({dout, dout_v, done, busy, serr} !== {m_out, m_ov, m_done, m_busy, m_serr}) begin
            bad++;
            $display("FAIL cycle_compare t=%0t got out=%h ov=%b done=%b busy=%b serr=%b want out=%h ov=%b done=%b busy=%b serr=%b",
                     $time, dout, dout_v, done, busy, serr, m_out, m_ov, m_done, m_busy, m_serr);
        end
        if (dout_v) log_q.push_back(dout);
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [LW-1:0] l, input logic v, input logic b);
        start = 1'b1; len = l; din_v = v; din = b;
        tick();
        start = 1'b0; din_v = 1'b0; din = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        din = b; din_v = 1'b1;
        tick();
        din_v = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < 8; i++) send_bit(b[i], gap);
    endtask

    task automatic send_zeros(input int n, input int gap);
        for (int i = 0; i < n; i++) send_bit(1'b0, gap);
    endtask

    task automatic new_test();
        log_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        logic [7:0] exp_b;
        repeat (3) tick();
        check("reset_outputs", {dout, dout_v, done, busy, serr}, 12'h000);
        rst = 1'b0;
        tick();

        // Two-byte frame with tail
        new_test();
        do_start(12'd2, 1'b0, 1'b0);
        check("busy_after_start", busy, 1);
        send_zeros(SB, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        check("last_strobe_ov_done_busy", {dout, dout_v, done, busy}, {8'hAA, 3'b110});
        for (int i = 0; i < 6; i++) send_bit(i[0], 0);
        tick();
        check("t1_count", log_q.size(), 2);
        check("t1_byte0", log_q[0], 8'h01);
        check("t1_byte1", log_q[1], 8'hAA);
        check("t1_done", done_cnt, 1);
        check("t1_serr", serr, 0);
        check("t1_hold", dout, 8'hAA);

        // Zero-length frame
        new_test();
        do_start(12'd0, 1'b0, 1'b0);
        send_zeros(SB, 0);
        check("t2_done_busy", {done, busy}, 2'b10);
        tick();
        check("t2_done_low", done, 0);
        send_zeros(4, 0);
        check("t2_no_strobe", log_q.size(), 0);
        check("t2_done_cnt", done_cnt, 1);

        // SERVICE bit 5 set
        new_test();
        do_start(12'd1, 1'b0, 1'b0);
        send_zeros(5, 0);
        check("t3_serr_before", serr, 0);
        send_bit(1'b1, 0);
        check("t3_serr_set", serr, 1);
        send_zeros(SB - 6, 0);
        send_byte(8'h5C, 0);
        tick();
        check("t3_byte", log_q[0], 8'h5C);
        check("t3_serr_hold", serr, 1);
        do_start(12'd0, 1'b0, 1'b0);
        check("t3_serr_clear", serr, 0);

        // Gappy input 1,0,0,1
        new_test();
        do_start(12'd3, 1'b0, 1'b0);
        send_zeros(SB, 2);
        send_byte(8'h3C, 2);
        send_byte(8'h81, 2);
        send_byte(8'h7E, 2);
        tick();
        check("t4_count", log_q.size(), 3);
        check("t4_b0", log_q[0], 8'h3C);
        check("t4_b1", log_q[1], 8'h81);
        check("t4_b2", log_q[2], 8'h7E);
        check("t4_done", done_cnt, 1);

        // Abort mid-PSDU; restart coincides with a valid 1 that must not count
        new_test();
        do_start(12'd4, 1'b0, 1'b0);
        send_zeros(SB, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        do_start(12'd1, 1'b1, 1'b1);
        send_zeros(SB, 0);
        check("t5_serr", serr, 0);
        send_byte(8'hC3, 0);
        tick();
        check("t5_count", log_q.size(), 3);
        check("t5_b2", log_q[2], 8'hC3);
        check("t5_done", done_cnt, 1);

        // Asynchronous reset mid-PSDU
        new_test();
        do_start(12'd2, 1'b0, 1'b0);
        send_zeros(SB, 0);
        send_byte(8'h55, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        #1 rst = 1'b1;
        #1 check("t6_async_zero", {dout, dout_v, done, busy, serr}, 12'h000);
        @(posedge clk);
        #4 rst = 1'b0;
        tick();
        for (int i = 0; i < 24; i++) send_bit(1'b1, 0);
        check("t6_after_rel", {dout, busy, serr}, 10'h000);
        check("t6_count", log_q.size(), 1);
        check("t6_done", done_cnt, 0);

        // Full-scale length
        new_test();
        do_start(12'hFFF, 1'b0, 1'b0);
        send_zeros(SB, 0);
        for (int i = 0; i < 4095; i++) begin
            exp_b = 8'((i * 7 + 3) & 255);
            send_byte(exp_b, 0);
        end
        tick();
        check("t7_count", log_q.size(), 4095);
        check("t7_last", log_q[4094], 8'hF5);
        check("t7_done", done_cnt, 1);
        check("t7_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psdu_extractor.md
PSDU_EXTRACTOR -- requirements
Module: psdu_extractor

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 12, giving the width of the PSDU LENGTH field in bytes.
REQ-002 SHALL have parameter SERVICE_BITS, default 16, giving the number of SERVICE bits that lead the DATA field.
REQ-003 Port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-high reset.
REQ-005 Port Start  input  1  one-cycle pulse that begins a frame and captures Length.
REQ-006 Port Length  input  LEN_WIDTH  PSDU length in bytes, sampled only when Start=1.
REQ-007 Port Input  input  1  descrambled data bit from DeScrambler, valid when InputValid=1.
REQ-008 Port InputValid  input  1  qualifies Input; bits with InputValid=0 are ignored.
REQ-009 Port Output  output  8  assembled PSDU byte.
REQ-010 Port OutputValid  output  1  one-cycle strobe marking Output valid.
REQ-011 Port Done  output  1  one-cycle pulse after the last PSDU byte, or after SERVICE when Length=0.
REQ-012 Port Busy  output  1  high from the cycle after Start until Done.
REQ-013 Port ServiceError  output  1  sticky per frame; set if any descrambled SERVICE bit was 1.

Function
REQ-014 SHALL implement the FSM states IDLE, SERVICE, PSDU and DRAIN.
REQ-015 IDLE: waits for Start; on Start, latch Length, clear the bit and byte counters, clear ServiceError, and go to SERVICE.
REQ-016 SERVICE: count SERVICE_BITS valid bits and OR each bit into ServiceError.
REQ-017 SERVICE exit, Length=0: on the last SERVICE bit, pulse Done in the next cycle and go to DRAIN.
REQ-018 SERVICE exit, Length>0: on the last SERVICE bit, go to PSDU.
REQ-019 PSDU: shift valid bits LSB-first, so the first received bit of a byte lands in Output[0].
REQ-020 PSDU: on the 8th valid bit of a byte, the next cycle drives Output with the completed byte and pulses OutputValid for one cycle (latency 1 clock after the 8th bit's sampling edge).
REQ-021 PSDU byte counter: increments per emitted byte.
REQ-022 PSDU exit: when the byte counter reaches the latched Length, pulse Done in the same cycle as the final OutputValid and go to DRAIN.
REQ-023 DRAIN: discards all TAIL/PAD bits, with no OutputValid; stays until Start.
REQ-024 DRAIN: on Start, behaves as IDLE on Start (same captures and clears, then SERVICE).
REQ-025 Start in SERVICE or PSDU SHALL abort the current frame: no Done for the aborted frame, partial byte discarded, restart per REQ-015 in the same edge.
REQ-026 Start coincident with InputValid=1 SHALL NOT count that bit; the first counted bit is the next valid bit.
REQ-027 Output SHALL hold its last value between strobes.
REQ-028 Busy SHALL deassert in the cycle Done pulses.
REQ-029 ServiceError SHALL hold until the next Start.
REQ-030 Length=2^LEN_WIDTH-1 SHALL be supported without counter overflow (byte counter width LEN_WIDTH).
REQ-031 InputValid gaps of any length SHALL be tolerated in every state without loss or duplication of bits.

Reset
REQ-032 Reset=1 SHALL immediately, without waiting for Clock, force state IDLE.
REQ-033 Reset=1 SHALL force Output=8'h00, OutputValid=0, Done=0, Busy=0 and ServiceError=0.
REQ-034 Reset=1 SHALL clear all counters and the shift register.
REQ-035 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL ignore Input until Start.

Verification
REQ-036 Start, Length=2; 16 zero bits; then bits 1,0,0,0,0,0,0,0, 0,1,0,1,0,1,0,1; then 6 tail bits -> OutputValid twice with Output=8'h01 then 8'hAA; Done with the second strobe; ServiceError=0; no strobes during tail.
REQ-037 Start, Length=0; 16 zero bits -> Done exactly one cycle after the 16th bit; OutputValid never asserted; Busy low after Done.
REQ-038 Start, Length=1; SERVICE bit 5 = 1 -> ServiceError=1 from that bit onward; byte still delivered; ServiceError cleared by the next Start.
REQ-039 Length=3 with InputValid toggling 1,0,0,1 throughout -> bytes identical to the gap-free run; one Done.
REQ-040 Start Length=4; after 20 PSDU bits a new Start with Length=1 -> no Done for the first frame; second frame produces one correct byte and Done.
REQ-041 Reset pulse asynchronous to Clock mid-PSDU -> all outputs zero while asserted; Input bits after release produce nothing until Start.
